// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction fetch sequencer.
//   fetch_state_t : fetch FSM states (SETTLE, WAIT, HALTED)
//   halt_opcode() : the halt instruction (all ones) for a given word width
package fetch_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Returns an all-ones word of the requested width (up to 64 bits),
  // zero-extended to 64 bits so callers can cast it down to their width.
  function automatic logic [63:0] halt_opcode(input int width);
    logic [63:0] word;
    word = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        word[i] = 1'b1;
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Program counter and fetch sequencer between the instruction BRAM medium
// and the decode stage.
//
// Parameters:
//   ADDRS        instruction memory depth in words (any value, not only 2^n)
//   INSTR_WIDTH  instruction word width
//   ADDR_SIZE    derived address width, $clog2(ADDRS)
//
// Ports:
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   addr_out         fetch address to the medium (the current pc)
//   instruction_in   word returned by the medium
//   valid_in         medium valid flag for addr_out
//   instr_out        held instruction presented to decode
//   pc_out           address of instr_out
//   instr_valid_out  output slot full
//   instr_ready_in   decode accepts the slot this cycle
//   jump_valid_in    single-cycle redirect request
//   jump_addr_in     redirect target
//
// Optional feature macro: INSTRUCTION_FETCH_HALT_EN
//   When defined, capturing an all-ones word delivers it to decode and then
//   parks the sequencer in HALTED until a jump or reset.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter  int ADDRS       = 256,
  parameter  int INSTR_WIDTH = 8,
  localparam int ADDR_SIZE   = $clog2(ADDRS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  output logic [ADDR_SIZE-1:0]   addr_out,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  input  logic                   valid_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [ADDR_SIZE-1:0]   pc_out,
  output logic                   instr_valid_out,
  input  logic                   instr_ready_in,
  input  logic                   jump_valid_in,
  input  logic [ADDR_SIZE-1:0]   jump_addr_in
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(ADDRS - 1);

`ifdef INSTRUCTION_FETCH_HALT_EN
  localparam logic [INSTR_WIDTH-1:0] HALT_OPCODE = INSTR_WIDTH'(halt_opcode(INSTR_WIDTH));
`endif

  fetch_state_t           state_q, state_d;
  logic [ADDR_SIZE-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instrOut_q, instrOut_d;
  logic [ADDR_SIZE-1:0]   pcOut_q, pcOut_d;
  logic                   instrValid_q, instrValid_d;
  logic [ADDR_SIZE-1:0]   nextPc;

  // The memory depth need not be a power of two, so the wrap to address 0
  // is an explicit compare against the last valid address.
  assign nextPc = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_SIZE'(1);

  // Next-state logic. A jump overrides everything: the held word is dropped
  // and the new address gets a SETTLE cycle, during which valid_in may still
  // belong to the old address and must be ignored. Otherwise a word is
  // captured in WAIT once the medium is valid and the slot is free or being
  // emptied this very cycle, so backpressure release costs no bubble.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instrOut_d   = instrOut_q;
    pcOut_d      = pcOut_q;
    instrValid_d = instrValid_q;

    if (jump_valid_in) begin
      pc_d         = jump_addr_in;
      instrValid_d = 1'b0;
      state_d      = SETTLE;
    end else begin
      if (instrValid_q && instr_ready_in) begin
        instrValid_d = 1'b0;
      end

      case (state_q)
        SETTLE: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (valid_in && (!instrValid_q || instr_ready_in)) begin
            instrOut_d   = instruction_in;
            pcOut_d      = pc_q;
            instrValid_d = 1'b1;
            pc_d         = nextPc;
            state_d      = SETTLE;
`ifdef INSTRUCTION_FETCH_HALT_EN
            if (instruction_in == HALT_OPCODE) begin
              state_d = HALTED;
            end
`endif
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = SETTLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset back to a clean fetch of address 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= SETTLE;
      pc_q         <= '0;
      instrOut_q   <= '0;
      pcOut_q      <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instrOut_q   <= instrOut_d;
      pcOut_q      <= pcOut_d;
      instrValid_q <= instrValid_d;
    end
  end

  assign addr_out        = pc_q;
  assign instr_out       = instrOut_q;
  assign pc_out          = pcOut_q;
  assign instr_valid_out = instrValid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// Self-checking bench for instruction_fetch with ADDRS=200, INSTR_WIDTH=8.
// A medium model returns addr^8'h5A (word 3 is 8'hFF) and raises valid two
// edges after the address changes. A transaction-level model predicts the
// outputs every cycle; directed literal checks pin key moments.
// Build with INSTRUCTION_FETCH_HALT_EN to exercise the halt feature.
module tb_instruction_fetch;

  localparam int ADDRS = 200;

`ifdef INSTRUCTION_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] addr_out;
  logic [7:0] instruction_in;
  logic       valid_in;
  logic [7:0] instr_out;
  logic [7:0] pc_out;
  logic       instr_valid_out;
  logic       instr_ready_in;
  logic       jump_valid_in;
  logic [7:0] jump_addr_in;

  int compared   = 0;
  int mismatched = 0;

  instruction_fetch #(
    .ADDRS       (ADDRS),
    .INSTR_WIDTH (8)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .addr_out        (addr_out),
    .instruction_in  (instruction_in),
    .valid_in        (valid_in),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid_out (instr_valid_out),
    .instr_ready_in  (instr_ready_in),
    .jump_valid_in   (jump_valid_in),
    .jump_addr_in    (jump_addr_in)
  );

  always #5 clk_in = ~clk_in;

  // Memory contents seen by the fetch unit.
  function automatic logic [7:0] memWord(input int addr);
    if (addr == 3) return 8'hFF;
    return 8'(addr) ^ 8'h5A;
  endfunction

  // Medium model: valid drops on the edge after an address change (or
  // after reset) and rises again one edge later.
  logic [7:0] prevAddr  = 8'h00;
  logic       rstSeen   = 1'b0;
  int         stableCnt = 0;

  assign instruction_in = memWord(int'(addr_out));
  assign valid_in       = (stableCnt >= 1);

  always @(posedge clk_in) begin
    prevAddr <= addr_out;
    rstSeen  <= rst_in;
    if (rstSeen || (addr_out !== prevAddr)) stableCnt <= 0;
    else if (stableCnt < 3) stableCnt <= stableCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction model: a word can be taken once its address has been on
  // the bus for two full edges, provided the slot is free or draining.
  bit modelKnown  = 1'b0;
  int mPc         = 0;
  int mAge        = 0;
  bit mValid      = 1'b0;
  int mInstr      = 0;
  int mSlotPc     = 0;
  bit mHalted     = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      mPc = 0; mAge = 0; mValid = 1'b0; mInstr = 0; mSlotPc = 0; mHalted = 1'b0;
      modelKnown = 1'b1;
    end else if (modelKnown) begin
      if (jump_valid_in) begin
        mPc = int'(jump_addr_in); mAge = 0; mValid = 1'b0; mHalted = 1'b0;
      end else if (!mHalted && mAge >= 2 && (!mValid || instr_ready_in)) begin
        mInstr  = int'(memWord(mPc));
        mSlotPc = mPc;
        mValid  = 1'b1;
        mHalted = HALT_EN && (mInstr == 255);
        mPc     = (mPc + 1) % ADDRS;
        mAge    = 0;
      end else begin
        if (mValid && instr_ready_in) mValid = 1'b0;
        if (mAge < 1000) mAge++;
      end
    end
  end

  // Compare the DUT against the model on every cycle after reset.
  always @(negedge clk_in) begin
    if (modelKnown) begin
      checkOutput("model.valid", 32'(instr_valid_out), 32'(mValid));
      checkOutput("model.addr", 32'(addr_out), 32'(mPc));
      if (mValid) begin
        checkOutput("model.instr", 32'(instr_out), 32'(mInstr));
        checkOutput("model.pc", 32'(pc_out), 32'(mSlotPc));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic jv,
                               input logic [7:0] ja, input logic rdy);
    rst_in         = rst;
    jump_valid_in  = jv;
    jump_addr_in   = ja;
    instr_ready_in = rdy;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic checkSlot(input string name, input logic v,
                           input logic [7:0] pc, input logic [7:0] ins);
    checkOutput({name, ".valid"}, 32'(instr_valid_out), 32'(v));
    checkOutput({name, ".pc"}, 32'(pc_out), 32'(pc));
    checkOutput({name, ".instr"}, 32'(instr_out), 32'(ins));
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    stepCycles(3);

    // Reset release: first word three edges later.
    checkSlot("reset", 1'b0, 8'h00, 8'h00);
    checkOutput("reset.addr", 32'(addr_out), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(1);
    checkOutput("first.e1.valid", 32'(instr_valid_out), 32'h0);
    stepCycles(1);
    checkOutput("first.e2.valid", 32'(instr_valid_out), 32'h0);
    stepCycles(1);
    checkSlot("first.e3", 1'b1, 8'h00, 8'h5A);
    checkOutput("first.e3.addr", 32'(addr_out), 32'h1);

    // Backpressure for 10 cycles: slot and address frozen.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      stepCycles(1);
      checkSlot("hold", 1'b1, 8'h00, 8'h5A);
      checkOutput("hold.addr", 32'(addr_out), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(1);
    checkSlot("release", 1'b1, 8'h01, 8'h5B);

    // Jump to 0x40 while the slot is full and being accepted.
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b1);
    stepCycles(1);
    checkOutput("jump40.flush", 32'(instr_valid_out), 32'h0);
    checkOutput("jump40.addr", 32'(addr_out), 32'h40);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(2);
    checkOutput("jump40.e2.valid", 32'(instr_valid_out), 32'h0);
    stepCycles(1);
    checkSlot("jump40.e3", 1'b1, 8'h40, 8'h1A);

    // Wrap at the last address of a non power-of-two memory.
    applyStimulus(1'b0, 1'b1, 8'd199, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(3);
    checkSlot("wrap.last", 1'b1, 8'd199, 8'h9D);
    stepCycles(3);
    checkSlot("wrap.zero", 1'b1, 8'd0, 8'h5A);
    stepCycles(3);
    checkSlot("thru.pc1", 1'b1, 8'd1, 8'h5B);
    stepCycles(6);
    checkSlot("allones", 1'b1, 8'd3, 8'hFF);

`ifdef INSTRUCTION_FETCH_HALT_EN
    for (int i = 0; i < 50; i++) begin
      stepCycles(1);
      checkOutput("halted.valid", 32'(instr_valid_out), 32'h0);
      checkOutput("halted.addr", 32'(addr_out), 32'h4);
    end
`else
    stepCycles(3);
    checkSlot("nohalt.pc4", 1'b1, 8'd4, 8'h5E);
    stepCycles(47);
`endif

    // Jump to 0 resumes fetching (leaves HALTED when enabled).
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    stepCycles(1);
    checkOutput("resume.addr", 32'(addr_out), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(3);
    checkSlot("resume", 1'b1, 8'd0, 8'h5A);

    // Reset while waiting with a full slot.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    stepCycles(3);
    checkSlot("prereset", 1'b1, 8'd0, 8'h5A);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    stepCycles(1);
    checkSlot("midreset", 1'b0, 8'd0, 8'h00);
    checkOutput("midreset.addr", 32'(addr_out), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    stepCycles(1);
    checkOutput("postreset.e1.valid", 32'(instr_valid_out), 32'h0);
    stepCycles(1);
    checkOutput("postreset.e2.valid", 32'(instr_valid_out), 32'h0);
    stepCycles(1);
    checkSlot("postreset.e3", 1'b1, 8'd0, 8'h5A);

    stepCycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
